nand_read_unit: RTL

Data-out read engine of the ONFI NAND controller: the receive-side counterpart of the command/address latch unit. It generates the RE# strobe sequence for a burst of data-output cycles, samples the NAND I/O bus at the end of each RE# low phase, and presents each word on a single-entry valid/ready output towards the page buffer. It is driven by the controller FSM after a read command and address cycles have completed and tR/tRR have elapsed.

---
 rtl/nand_read_unit_pkg.sv | 28 ++
 rtl/nand_delay_counter.sv | 26 ++
 rtl/nand_read_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nand_read_unit_pkg.sv
// Shared ONFI controller definitions: timing constants in clk cycles,
// read-engine state encoding and the bus-width helper.
package nand_read_unit_pkg;

    // Write-side timing used by the command/address latch unit
    localparam int t_wp   = 2;
    localparam int t_wh   = 2;
    localparam int t_clh  = 1;

    // Read-side timing; t_rp must cover t_rea because data is sampled at the end of RE# low
    localparam int t_rp   = 2;
    localparam int t_reh  = 2;
    localparam int t_rea  = 2;
    localparam int t_rhoh = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_STALL = 2'd3
    } rd_state_t;

    // x8 devices only drive IO[7:0]; the upper byte is undefined and forced to zero
    function automatic logic [15:0] bus_word(input logic x16, input logic [15:0] d);
        return x16 ? d : {8'h00, d[7:0]};
    endfunction

endpackage

// File: rtl/nand_delay_counter.sv
// Loadable down-counter; expired flags the final cycle of a loaded interval.
module nand_delay_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Load wins; otherwise count down and park at zero
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign expired = (cnt == W'(1));

endmodule

// File: rtl/nand_read_unit.sv
// ONFI data-out engine: drives RE# pulses, samples the I/O bus at the end of
// each low phase and offers each word on a single-entry valid/ready slot.
module nand_read_unit
    import nand_read_unit_pkg::*;
#(
    parameter int T_RP  = t_rp,
    parameter int T_REH = t_reh
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        activate,
    input  logic [15:0] count,
    input  logic        bus_x16,
    input  logic [15:0] nand_data_in,
    output logic        read_enable,
    output logic [15:0] data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        busy,
    output logic        done
);

    rd_state_t   state;
    logic [15:0] remaining;
    logic        x16_q;
    logic        dly_load;
    logic [15:0] dly_val;
    logic        dly_expired;
    logic        slot_free;
    logic        phase_end;

    // Slot may be refilled when empty or being drained this cycle
    assign slot_free = !data_valid || data_ready;
    // End of RE# high time, or any cycle spent waiting in STALL
    assign phase_end = (state == ST_HIGH && dly_expired) || (state == ST_STALL);

    // Reload the delay counter on every entry into LOW or HIGH
    always_comb begin
        dly_load = 1'b0;
        dly_val  = 16'(T_RP);
        case (state)
            ST_IDLE:  dly_load = activate && (count != 16'd0);
            ST_LOW: begin
                dly_load = dly_expired;
                dly_val  = 16'(T_REH);
            end
            ST_HIGH:  dly_load = dly_expired && (remaining != 16'd0) && slot_free;
            ST_STALL: dly_load = (remaining != 16'd0) && slot_free;
            default:  dly_load = 1'b0;
        endcase
    end

    nand_delay_counter #(.W(16)) u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (dly_load),
        .load_val (dly_val),
        .expired  (dly_expired)
    );

    // Burst sequencer with registered RE#, slot and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            remaining   <= 16'd0;
            x16_q       <= 1'b0;
            read_enable <= 1'b1;
            data_out    <= 16'd0;
            data_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (data_valid && data_ready)
                data_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    read_enable <= 1'b1;
                    busy        <= 1'b0;
                    if (activate) begin
                        if (count != 16'd0) begin
                            remaining   <= count;
                            x16_q       <= bus_x16;
                            read_enable <= 1'b0;
                            busy        <= 1'b1;
                            state       <= ST_LOW;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_LOW: begin
                    // Sample coincides with RE# rising; slot is always empty here
                    if (dly_expired) begin
                        data_out    <= bus_word(x16_q, nand_data_in);
                        data_valid  <= 1'b1;
                        read_enable <= 1'b1;
                        remaining   <= remaining - 16'd1;
                        state       <= ST_HIGH;
                    end
                end
                ST_HIGH, ST_STALL: begin
                    read_enable <= 1'b1;
                    if (phase_end) begin
                        if (!slot_free) begin
                            state <= ST_STALL;
                        end else if (remaining == 16'd0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            read_enable <= 1'b0;
                            state       <= ST_LOW;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
